// File: rtl/ppu_bg_fetch.sv
// NES PPU background pipeline: loopy scroll counters, NT/AT/PT fetch FSM and pixel shifters.
// Optional PPU_BG_CLIP_EN: force palette_idx_out to 0 in pixels 0..7 while clip_in=1.
module ppu_bg_fetch #(
  parameter int PREFETCH_TILES = 2,
  parameter int SHIFT_W        = 8 * PREFETCH_TILES
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  input  logic [2:0]  fv_in,
  input  logic [4:0]  vt_in,
  input  logic        v_in,
  input  logic [2:0]  fh_in,
  input  logic [4:0]  ht_in,
  input  logic        h_in,
  input  logic        s_in,
  input  logic [9:0]  nes_x_in,
  input  logic [9:0]  nes_y_in,
  input  logic [9:0]  nes_y_next_in,
  input  logic        pix_pulse_in,
  input  logic [7:0]  vram_d_in,
  input  logic        vram_ack_in,
  output logic        vram_req_out,
  output logic [13:0] vram_a_out,
  input  logic        ri_upd_cntrs_in,
  input  logic        ri_inc_addr_in,
  input  logic        ri_inc_addr_amt_in,
  input  logic        clip_in,
  output logic [3:0]  palette_idx_out,
  output logic        underrun_out,
  output logic [2:0]  fsm_state_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NT   = 3'd1,
    S_AT   = 3'd2,
    S_PT0  = 3'd3,
    S_PT1  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [9:0] X_PF_END = 10'(320 + 8 * PREFETCH_TILES);

  state_t r_state, w_state_nxt;

  logic [2:0] r_fvc;
  logic [4:0] r_vtc;
  logic       r_vc;
  logic [4:0] r_htc;
  logic       r_hc;

  logic [7:0] r_par;
  logic [1:0] r_ar;
  logic [7:0] r_pd0, r_pd1;

  logic [SHIFT_W-1:0] r_bit0, r_bit1;
  logic [SHIFT_W-8:0] r_bit2, r_bit3;
  logic               r_underrun;

  logic       w_y_active, w_x_active, w_window;
  logic       w_load_pt, w_shift_pt, w_line_end, w_v_load, w_v_inc;
  logic       w_underrun_evt;
  logic [1:0] w_at_bits;
  logic [7:0] w_ld_pd0, w_ld_pd1;
  logic [1:0] w_ld_ar;
  logic       w_clip;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign w_y_active = en_in && ((nes_y_in < 10'd240) || (nes_y_next_in == 10'd0));
  assign w_x_active = (nes_x_in < 10'd256) || ((nes_x_in >= 10'd320) && (nes_x_in < X_PF_END));
  assign w_window   = w_y_active && w_x_active;

  assign w_load_pt      = pix_pulse_in && w_window && (nes_x_in[2:0] == 3'd7);
  assign w_shift_pt     = pix_pulse_in && w_window && !w_load_pt;
  assign w_line_end     = pix_pulse_in && w_y_active && (nes_x_in == 10'd319);
  assign w_v_load       = w_line_end && (nes_y_next_in == 10'd0);
  assign w_v_inc        = w_line_end && !w_v_load && (nes_y_next_in != nes_y_in);
  assign w_underrun_evt = w_load_pt && (r_state != S_DONE);

  // Scroll counters; register-interface increment beats a counter load, which beats scroll events.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_fvc <= 3'd0;
      r_vtc <= 5'd0;
      r_vc  <= 1'b0;
      r_htc <= 5'd0;
      r_hc  <= 1'b0;
    end else if (ri_inc_addr_in) begin
      if (ri_inc_addr_amt_in)
        {r_fvc, r_vc, r_hc, r_vtc} <= {r_fvc, r_vc, r_hc, r_vtc} + 10'd1;
      else
        {r_fvc, r_vc, r_hc, r_vtc, r_htc} <= {r_fvc, r_vc, r_hc, r_vtc, r_htc} + 15'd1;
    end else if (ri_upd_cntrs_in) begin
      {r_fvc, r_vc, r_hc, r_vtc, r_htc} <= {fv_in, v_in, h_in, vt_in, ht_in};
    end else begin
      if (w_line_end)
        {r_hc, r_htc} <= {h_in, ht_in};
      else if (w_load_pt)
        {r_hc, r_htc} <= {r_hc, r_htc} + 6'd1;
      if (w_v_load) begin
        {r_vc, r_vtc, r_fvc} <= {v_in, vt_in, fv_in};
      end else if (w_v_inc) begin
        if ((r_vtc == 5'd29) && (r_fvc == 3'd7)) begin
          r_vtc <= 5'd0;
          r_fvc <= 3'd0;
          r_vc  <= ~r_vc;
        end else begin
          {r_vc, r_vtc, r_fvc} <= {r_vc, r_vtc, r_fvc} + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_underrun <= 1'b0;
    else if (w_underrun_evt)
      r_underrun <= 1'b1;
    else if (w_v_load && !ri_inc_addr_in && !ri_upd_cntrs_in)
      r_underrun <= 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Handshake: vram_req_out stays high for the whole fetch state; the cycle with
  // vram_ack_in=1 completes the read, vram_d_in is captured then and the FSM advances.
  always_comb begin
    w_state_nxt  = r_state;
    vram_req_out = 1'b0;
    vram_a_out   = {r_fvc[1:0], r_vc, r_hc, r_vtc, r_htc};
    case (r_state)
      S_IDLE: if (w_window && (nes_x_in[2:0] == 3'd0)) w_state_nxt = S_NT;
      S_NT: begin
        vram_req_out = 1'b1;
        vram_a_out   = {2'b10, r_vc, r_hc, r_vtc, r_htc};
        if (vram_ack_in) w_state_nxt = S_AT;
      end
      S_AT: begin
        vram_req_out = 1'b1;
        vram_a_out   = {2'b10, r_vc, r_hc, 4'b1111, r_vtc[4:2], r_htc[4:2]};
        if (vram_ack_in) w_state_nxt = S_PT0;
      end
      S_PT0: begin
        vram_req_out = 1'b1;
        vram_a_out   = {1'b0, s_in, r_par, 1'b0, r_fvc};
        if (vram_ack_in) w_state_nxt = S_PT1;
      end
      S_PT1: begin
        vram_req_out = 1'b1;
        vram_a_out   = {1'b0, s_in, r_par, 1'b1, r_fvc};
        if (vram_ack_in) w_state_nxt = S_DONE;
      end
      S_DONE: if (w_load_pt) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!en_in || w_underrun_evt) w_state_nxt = S_IDLE;
  end

  // Attribute quadrant select: byte >> {VT[1],HT[1],0}, low two bits.
  always_comb begin
    w_at_bits = vram_d_in[1:0];
    case ({r_vtc[1], r_htc[1]})
      2'b00:   w_at_bits = vram_d_in[1:0];
      2'b01:   w_at_bits = vram_d_in[3:2];
      2'b10:   w_at_bits = vram_d_in[5:4];
      default: w_at_bits = vram_d_in[7:6];
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_par <= 8'd0;
      r_ar  <= 2'd0;
      r_pd0 <= 8'd0;
      r_pd1 <= 8'd0;
    end else if (vram_ack_in) begin
      case (r_state)
        S_NT:    r_par <= vram_d_in;
        S_AT:    r_ar  <= w_at_bits;
        S_PT0:   r_pd0 <= vram_d_in;
        S_PT1:   r_pd1 <= vram_d_in;
        default: ;
      endcase
    end
  end

  assign w_ld_pd0 = w_underrun_evt ? 8'd0 : r_pd0;
  assign w_ld_pd1 = w_underrun_evt ? 8'd0 : r_pd1;
  assign w_ld_ar  = w_underrun_evt ? 2'd0 : r_ar;

  // Bit 0 of each shifter is the current pixel; new tiles enter reversed at the top.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bit0 <= '0;
      r_bit1 <= '0;
      r_bit2 <= '0;
      r_bit3 <= '0;
    end else if (w_load_pt) begin
      r_bit0 <= {rev8(w_ld_pd0), r_bit0[SHIFT_W-8:1]};
      r_bit1 <= {rev8(w_ld_pd1), r_bit1[SHIFT_W-8:1]};
      r_bit2 <= {w_ld_ar[0], r_bit2[SHIFT_W-8:1]};
      r_bit3 <= {w_ld_ar[1], r_bit3[SHIFT_W-8:1]};
    end else if (w_shift_pt) begin
      r_bit0 <= {1'b0, r_bit0[SHIFT_W-1:1]};
      r_bit1 <= {1'b0, r_bit1[SHIFT_W-1:1]};
      r_bit2 <= {r_bit2[SHIFT_W-8], r_bit2[SHIFT_W-8:1]};
      r_bit3 <= {r_bit3[SHIFT_W-8], r_bit3[SHIFT_W-8:1]};
    end
  end

`ifdef PPU_BG_CLIP_EN
  assign w_clip = clip_in && (nes_x_in < 10'd8);
`else
  assign w_clip = clip_in & 1'b0;
`endif

  assign palette_idx_out = w_clip ? 4'd0
                         : {r_bit3[fh_in], r_bit2[fh_in], r_bit1[fh_in], r_bit0[fh_in]};
  assign underrun_out    = r_underrun;
  assign fsm_state_out   = r_state;

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Directed bench for ppu_bg_fetch: rendering, underrun, scroll counters, register interface, async reset.
module tb_ppu_bg_fetch;

  logic        clk, rst, en;
  logic [2:0]  fv, fh;
  logic [4:0]  vt, ht;
  logic        v, h, s;
  logic [9:0]  nes_x, nes_y, nes_y_next;
  logic        pix_pulse;
  logic [7:0]  vram_d;
  logic        vram_ack, vram_req;
  logic [13:0] vram_a;
  logic        ri_upd, ri_inc, ri_amt, clip;
  logic [3:0]  palette_idx;
  logic        underrun;
  logic [2:0]  fsm_state;

  logic        ack_en;
  int          n_checks, n_fail;

`ifdef PPU_BG_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  ppu_bg_fetch dut (
    .clk_in(clk), .rst_in(rst), .en_in(en),
    .fv_in(fv), .vt_in(vt), .v_in(v), .fh_in(fh), .ht_in(ht), .h_in(h), .s_in(s),
    .nes_x_in(nes_x), .nes_y_in(nes_y), .nes_y_next_in(nes_y_next),
    .pix_pulse_in(pix_pulse), .vram_d_in(vram_d), .vram_ack_in(vram_ack),
    .vram_req_out(vram_req), .vram_a_out(vram_a),
    .ri_upd_cntrs_in(ri_upd), .ri_inc_addr_in(ri_inc), .ri_inc_addr_amt_in(ri_amt),
    .clip_in(clip), .palette_idx_out(palette_idx), .underrun_out(underrun),
    .fsm_state_out(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency VRAM: NT bytes 5Ah, AT bytes 00h, PT plane 0 FFh, plane 1 00h.
  assign vram_ack = vram_req & ack_en;
  always_comb begin
    vram_d = 8'h00;
    if (vram_a[13:12] == 2'b10)
      vram_d = (vram_a[9:6] == 4'b1111) ? 8'h00 : 8'h5A;
    else if (vram_a[13] == 1'b0)
      vram_d = vram_a[3] ? 8'h00 : 8'hFF;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel: 3 quiet clocks then a pix_pulse clock; palette sampled one clock in.
  task automatic do_pixel(input logic [9:0] x, output logic [3:0] pal,
                          output logic req_after, output logic urun_after);
    nes_x = x;
    pix_pulse = 1'b0;
    @(negedge clk);
    pal = palette_idx;
    @(negedge clk);
    @(negedge clk);
    pix_pulse = 1'b1;
    @(negedge clk);
    pix_pulse = 1'b0;
    req_after = vram_req;
    urun_after = underrun;
  endtask

  task automatic run_pixels(input int x0, input int x1);
    logic [3:0] p;
    logic r, u;
    for (int x = x0; x <= x1; x++) do_pixel(10'(x), p, r, u);
  endtask

  task automatic set_line(input int y, input int y_next);
    nes_y = 10'(y);
    nes_y_next = 10'(y_next);
  endtask

  task automatic force_idle();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    logic [3:0] pal;
    logic       req_a, urun_a;
    logic [3:0] exp_pal;

    n_checks = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b0; ack_en = 1'b1;
    fv = 3'd0; vt = 5'd0; v = 1'b0; fh = 3'd0; ht = 5'd0; h = 1'b0; s = 1'b0;
    nes_x = 10'd0; nes_y = 10'd0; nes_y_next = 10'd0; pix_pulse = 1'b0;
    ri_upd = 1'b0; ri_inc = 1'b0; ri_amt = 1'b0; clip = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 16'(vram_req), 16'd0);
    chk("rst_addr", 16'(vram_a), 16'h0000);
    chk("rst_pal", 16'(palette_idx), 16'd0);
    chk("rst_urun", 16'(underrun), 16'd0);
    chk("rst_state", 16'(fsm_state), 16'd0);
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);

    // Frame start: prefetch two tiles on the pre-render line, render line 0
    set_line(261, 0);
    run_pixels(319, 335);
    set_line(0, 1);
    clip = 1'b1;
    for (int x = 0; x < 16; x++) begin
      do_pixel(10'(x), pal, req_a, urun_a);
      exp_pal = (CLIP_EN && x < 8) ? 4'h0 : 4'h1;
      chk($sformatf("pix%0d", x), 16'(pal), 16'(exp_pal));
    end
    clip = 1'b0;
    chk("line0_urun", 16'(underrun), 16'd0);
    run_pixels(16, 255);
    chk("addr_hc_wrap", 16'(vram_a), 16'h0402);
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("addr_fv_inc", 16'(vram_a), 16'h1000);

    // Underrun: no acknowledge for the whole tile slot at x=0..7
    set_line(261, 0);
    run_pixels(319, 335);
    set_line(0, 1);
    ack_en = 1'b0;
    run_pixels(0, 5);
    do_pixel(10'd6, pal, req_a, urun_a);
    chk("stall_req", 16'(req_a), 16'd1);
    chk("stall_urun", 16'(urun_a), 16'd0);
    do_pixel(10'd7, pal, req_a, urun_a);
    chk("abort_req", 16'(req_a), 16'd0);
    chk("urun_set", 16'(urun_a), 16'd1);
    ack_en = 1'b1;
    for (int x = 8; x <= 24; x++) begin
      do_pixel(10'(x), pal, req_a, urun_a);
      if (x == 8)  chk("urun_pix8", 16'(pal), 16'h1);
      if (x == 16) chk("urun_pix16", 16'(pal), 16'h0);
      if (x == 23) chk("urun_pix23", 16'(pal), 16'h0);
      if (x == 24) chk("urun_pix24", 16'(pal), 16'h1);
    end
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("urun_sticky", 16'(urun_a), 16'd1);
    set_line(261, 0);
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("urun_clear", 16'(urun_a), 16'd0);
    force_idle();

    // Vertical wrap {VT,FV}={29,7} -> 0 with V toggle
    vt = 5'd29; fv = 3'd7; v = 1'b0; h = 1'b0; ht = 5'd0;
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("vload_29_7", 16'(vram_a), 16'h33A0);
    set_line(5, 6);
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("vwrap", 16'(vram_a), 16'h0800);
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("vinc_plain", 16'(vram_a), 16'h1800);

    // Register interface: load and increment
    ht = 5'd31; vt = 5'd0; fv = 3'd0; v = 1'b0; h = 1'b0;
    ri_upd = 1'b1;
    @(negedge clk);
    ri_upd = 1'b0;
    chk("ri_load", 16'(vram_a), 16'h001F);
    ri_inc = 1'b1; ri_amt = 1'b0;
    @(negedge clk);
    ri_inc = 1'b0;
    chk("ri_inc1", 16'(vram_a), 16'h0020);
    ri_inc = 1'b1; ri_amt = 1'b1;
    @(negedge clk);
    ri_inc = 1'b0;
    chk("ri_inc32", 16'(vram_a), 16'h0040);
    ri_inc = 1'b1; ri_upd = 1'b1;
    @(negedge clk);
    ri_inc = 1'b0; ri_upd = 1'b0; ri_amt = 1'b0;
    chk("ri_inc_prio", 16'(vram_a), 16'h0060);
    en = 1'b0;
    set_line(261, 0);
    do_pixel(10'd319, pal, req_a, urun_a);
    chk("en0_hold", 16'(vram_a), 16'h0060);
    ri_upd = 1'b1;
    @(negedge clk);
    ri_upd = 1'b0;
    chk("en0_ri_upd", 16'(vram_a), 16'h001F);

    // Asynchronous reset in the middle of PT0
    set_line(0, 1);
    nes_x = 10'd0;
    en = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ack_en = 1'b0;
    chk("pt0_state", 16'(fsm_state), 16'd3);
    chk("pt0_req", 16'(vram_req), 16'd1);
    chk("pt0_addr", 16'(vram_a), 16'h05A0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 16'(vram_req), 16'd0);
    chk("arst_state", 16'(fsm_state), 16'd0);
    chk("arst_addr", 16'(vram_a), 16'h0000);
    chk("arst_pal", 16'(palette_idx), 16'd0);
    chk("arst_urun", 16'(underrun), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
